// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment table for the 7-segment scan driver
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ALL   = 8'h00;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n lives at bits [8n+7:8n], dp kept off.
  localparam logic [16*8-1:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display value/strobe inputs and scanned digit outputs
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [31:0]        data;
  logic               load;
  logic               all_on;
  logic [DIGIT_W-1:0] which;
  logic [7:0]         seg;
  logic               frame_done;

  modport master (
    output data, load, all_on,
    input  which, seg, frame_done
  );

  modport slave (
    input  data, load, all_on,
    output which, seg, frame_done
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// rtl/seg7_scan_driver_hex_to_seg7.sv - combinational nibble to active-low segment decode
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Table lookup; the table already carries dp=1 so normal digits show no point.
  always_comb begin
    seg = HEX_SEG_TABLE[{nibble, 3'b000} +: 8];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit time-multiplexed hex display driver (SEG7_LZB_EN enables leading-zero blanking)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] idx_q, idx_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [7:0]         seg_q, seg_d;
  logic               frame_done_q, frame_done_d;

  logic               tick;
  logic [3:0]         cur_nibble;
  logic [7:0]         dec_seg;
  logic [NUM_DIGITS-1:0] blank_mask;

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEG7_LZB_EN
  // Blank every digit above the highest non-zero nibble; digit 0 always stays lit.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen          = seen | (|shadow_q[4*k +: 4]);
      blank_mask[k] = ~seen & (k != 0);
    end
  end
`else
  // All digits shown, leading zeros included.
  always_comb begin
    blank_mask = '0;
  end
`endif

  // Prescaler, digit index, shadow capture and the per-tick segment update.
  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 1'b1 : idx_q;
    shadow_d     = bus.load ? bus.data : shadow_q;
    cur_nibble   = shadow_q[{idx_d, 2'b00} +: 4];
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    if (tick) begin
      frame_done_d = (idx_q == LAST_DIGIT);
      if (bus.all_on) begin
        seg_d = SEG_ALL;
      end else if (blank_mask[idx_d]) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = dec_seg;
      end
    end
  end

  // State registers; reset leaves the display dark on digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.which      = idx_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with SCAN_DIV=4
module tb_seg7_scan_driver;

  localparam int DIV = 4;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] which;
    logic [7:0] seg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  exp_t sb[$];
  logic [31:0] model_shadow;

  seg7_scan_driver_if u_if ();

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input logic [31:0] sh, input int k, input bit ao);
    logic [31:0] upper;
    if (ao) return 8'h00;
    upper = sh >> (4 * k);
    if (LZB && k != 0 && upper == 32'd0) return 8'hFF;
    return ref_hex(upper[3:0]);
  endfunction

  task automatic push_frames(input logic [31:0] sh, input bit ao, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      exp_t e;
      idx     = (start + 1 + i) % 8;
      e.which = 3'(idx);
      e.seg   = ref_seg(sh, idx, ao);
      sb.push_back(e);
    end
  endtask

  task automatic load_value(input logic [31:0] v);
    u_if.data = v;
    u_if.load = 1'b1;
    @(negedge clk);
    u_if.load = 1'b0;
    model_shadow = v;
  endtask

  // Waits for n ticks, comparing each against the scoreboard; ends on the negedge after the last tick.
  task automatic collect(input int n);
    logic [2:0] prev;
    bit stray;
    stray = 1'b0;
    prev  = u_if.which;
    for (int i = 0; i < n; i++) begin
      int cycles;
      exp_t e;
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
        if (u_if.which == prev && u_if.frame_done) stray = 1'b1;
      end while (u_if.which == prev && cycles < 3 * DIV);
      total++;
      if (u_if.which == prev) begin
        $display("FAIL tick_timeout: which stuck at %0d after %0d cycles, expected a change", prev, cycles);
        sb.delete();
        return;
      end
      passed++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: got which=%0d with no expected entry, expected an entry", u_if.which);
        return;
      end
      passed++;
      e = sb.pop_front();
      total++;
      if (u_if.which !== e.which)
        $display("FAIL which: got %0d expected %0d", u_if.which, e.which);
      else passed++;
      total++;
      if (u_if.seg !== e.seg)
        $display("FAIL seg_digit%0d: got %h expected %h", e.which, u_if.seg, e.seg);
      else passed++;
      total++;
      if (u_if.frame_done !== (e.which == 3'd0))
        $display("FAIL frame_done_at_tick: got %b expected %b (which=%0d)", u_if.frame_done, (e.which == 3'd0), e.which);
      else passed++;
      if (i > 0) begin
        total++;
        if (cycles != DIV) $display("FAIL hold_cycles: got %0d expected %0d", cycles, DIV);
        else passed++;
      end
      prev = u_if.which;
    end
    total++;
    if (stray) $display("FAIL frame_done_stray: got pulse between ticks expected none");
    else passed++;
  endtask

  task automatic test_reset;
    // power-on reset values
    total++;
    if (u_if.which !== 3'd0 || u_if.seg !== 8'hFF || u_if.frame_done !== 1'b0)
      $display("FAIL reset_init: got which=%0d seg=%h fd=%b expected 0/ff/0", u_if.which, u_if.seg, u_if.frame_done);
    else passed++;
    rst_n = 1'b1;
    push_frames(32'hAAAA_AAAA, 1'b0, 0, 3);
    load_value(32'hAAAA_AAAA);
    collect(3);
    // asynchronous reset mid-scan
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (u_if.which !== 3'd0) $display("FAIL reset_which: got %0d expected 0", u_if.which);
    else passed++;
    total++;
    if (u_if.seg !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", u_if.seg);
    else passed++;
    total++;
    if (u_if.frame_done !== 1'b0) $display("FAIL reset_fd: got %b expected 0", u_if.frame_done);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_shadow = 32'd0;
    push_frames(32'd0, 1'b0, 0, 8);
    collect(8);
  endtask

  task automatic test_digits;
    push_frames(32'h1234_5678, 1'b0, int'(u_if.which), 8);
    load_value(32'h1234_5678);
    collect(8);
  endtask

  task automatic test_frame_done;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8 * DIV; i++) begin
      @(negedge clk);
      if (u_if.frame_done) begin
        pulses++;
        total++;
        if (u_if.which !== 3'd0) $display("FAIL fd_position: got which=%0d expected 0", u_if.which);
        else passed++;
      end
    end
    total++;
    if (pulses != 1) $display("FAIL fd_per_frame: got %0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_load_on_tick;
    exp_t e;
    int start;
    start = int'(u_if.which);
    push_frames(model_shadow, 1'b0, start, 1);
    repeat (DIV - 1) @(negedge clk);
    load_value(32'hDEAD_BEEF);
    total++;
    e = sb.pop_front();
    if (u_if.which !== e.which || u_if.seg !== e.seg)
      $display("FAIL load_tick_old: got which=%0d seg=%h expected which=%0d seg=%h", u_if.which, u_if.seg, e.which, e.seg);
    else passed++;
    push_frames(32'hDEAD_BEEF, 1'b0, start + 1, 7);
    collect(7);
  endtask

  task automatic test_all_on;
    u_if.all_on = 1'b1;
    push_frames(model_shadow, 1'b1, int'(u_if.which), 8);
    collect(8);
    u_if.all_on = 1'b0;
    push_frames(model_shadow, 1'b0, int'(u_if.which), 8);
    collect(8);
  endtask

  task automatic test_lzb;
    push_frames(32'h0000_00A5, 1'b0, int'(u_if.which), 8);
    load_value(32'h0000_00A5);
    collect(8);
    push_frames(32'd0, 1'b0, int'(u_if.which), 8);
    load_value(32'd0);
    collect(8);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    model_shadow = 32'd0;
    rst_n        = 1'b0;
    u_if.data    = 32'd0;
    u_if.load    = 1'b0;
    u_if.all_on  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_digits();
    test_frame_done();
    test_load_on_tick();
    test_all_on();
    test_lzb();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
